branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch/jump resolution stage for the 5-stage pipeline. Compares two register operands under one of six conditions, combines the result with the branch/jump controls, and produces a registered PC redirect plus a multi-cycle flush to squash younger instructions in IF/ID. Sits at the end of ID/EX and feeds the fetch PC mux and the IF/ID, ID/EX pipeline-register clears. An optional 2-bit dynamic predictor table limits flushes to mispredictions.

## Interface
Parameters:
- WIDTH, 16, operand width of a/b
- PC_WIDTH, 16, PC and target width
- FLUSH_CYCLES, 2, cycles flush stays high per redirect (legal 1..15)
- BHT_BITS, 4, log2 of predictor table depth (used only with BRANCH_PREDICT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  resolve request this cycle
- branch  in  1  instruction is a conditional branch
- jump  in  1  instruction is an unconditional jump
- branch_sel  in  3  compare condition
- a, b  in  WIDTH  operands
- pc_in  in  PC_WIDTH  PC of the resolving instruction
- target_in  in  PC_WIDTH  taken target
- pred_taken_in  in  1  prediction carried down the pipe for this instruction
- pred_pc  in  PC_WIDTH  fetch-stage PC for lookup
- pred_taken  out  1  combinational prediction for pred_pc
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  PC_WIDTH  corrected next PC
- flush  out  1  clear IF/ID and ID/EX

## Operation
- branch_sel: 000 BLT signed, 001 BGT signed, 010 BEQ, 011 BNE, 100 BLTU, 101 BGTU, 110/111 never taken.
- Comparisons full WIDTH; signed modes treat a/b as two's complement.
- taken = jump | (branch & cond). jump overrides branch_sel and branch.
- Accepted = valid_in & state IDLE. Requests in FLUSH are ignored (they belong to squashed instructions).
- Mispredict (accepted cycle): jump → always redirect to target_in; branch → redirect when taken != effective prediction; neither branch nor jump → no action.
- Redirect target: taken → target_in; not taken → pc_in + 1 (wraps modulo 2^PC_WIDTH).
- FSM: IDLE → FLUSH on accepted mispredict, loading counter with FLUSH_CYCLES; FLUSH decrements each cycle, returns to IDLE when counter reaches 1. No other transitions.
- Reset values: redirect_valid 0, redirect_pc 0, flush 0, state IDLE, counter 0, predictor entries 01. Reset asserted mid-flush aborts immediately.

## Timing
- Registered outputs, latency 1: accepted mispredict at edge t → redirect_valid high for cycle t+1 only; flush high cycles t+1 … t+FLUSH_CYCLES inclusive.
- redirect_pc holds its value until the next redirect.
- Back-to-back: a request arriving the cycle flush drops (state IDLE) is accepted normally.
- Predictor update happens at the same edge as resolution, so a same-cycle pred_pc lookup sees the pre-update value.

## Configuration
- BRANCH_PREDICT_EN defined: 2^BHT_BITS × 2-bit saturating counters indexed by PC[BHT_BITS-1:0]; pred_taken = counter[1] of pred_pc entry; every accepted branch (not jump) increments on taken, decrements on not-taken, saturating at 00/11; effective prediction = pred_taken_in.
- Not defined: no table; pred_taken tied 0; pred_taken_in ignored; effective prediction is always not-taken, so every taken branch and every jump redirects.

## Test plan
- Macro off, BLT, a=15 b=20, branch=1, target=0x0040 → redirect_valid pulse t+1, redirect_pc=0x0040, flush 2 cycles; a=20 b=15 → no flush.
- Signed vs unsigned: a=0xFFFF b=0x0001 → BLT taken, BLTU not taken; BGTU taken.
- Jump=1, branch_sel=110, a=b=10 → redirect to target; requests during the flush window produce no output and no table update.
- Macro on, entry 3 reset 01: branch at pc 0x0003 taken twice with pred_taken_in=pred_taken → first mispredicts (flush), counter 10; second predicted taken, no flush, counter 11.
- Macro on, predicted taken but not taken at pc 0xFFFF → redirect_pc=0x0000 (wrap).
- rst asserted in second flush cycle with FLUSH_CYCLES=3 → flush, redirect_valid drop asynchronously; state IDLE after release.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if
//   Bundles the resolve request, the predictor lookup and the redirect/flush
//   results exchanged between the pipeline control (master) and the
//   branch resolution unit (slave).
//
//   Signals:
//     valid_in, branch, jump, branch_sel : resolve request and condition select
//     a, b                               : compare operands (WIDTH)
//     pc_in, target_in                   : resolving PC and taken target (PC_WIDTH)
//     pred_taken_in                      : prediction carried down the pipe
//     pred_pc / pred_taken               : fetch-stage predictor lookup
//     redirect_valid, redirect_pc        : one-cycle PC load request
//     flush                              : clear IF/ID and ID/EX
interface branch_resolve_unit_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
);
  logic                valid_in;
  logic                branch;
  logic                jump;
  logic [2:0]          branch_sel;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] target_in;
  logic                pred_taken_in;
  logic [PC_WIDTH-1:0] pred_pc;
  logic                pred_taken;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                flush;

  modport master (
    output valid_in, branch, jump, branch_sel, a, b, pc_in, target_in,
           pred_taken_in, pred_pc,
    input  pred_taken, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  valid_in, branch, jump, branch_sel, a, b, pc_in, target_in,
           pred_taken_in, pred_pc,
    output pred_taken, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves branches/jumps at the end of ID/EX. Compares a/b under the
//   selected condition, decides whether the fetch stream was wrong, and
//   produces a registered PC redirect plus a FLUSH_CYCLES-long flush that
//   squashes the younger instructions in IF/ID and ID/EX.
//
//   Optional feature macro: BRANCH_PREDICT_EN
//     defined   : 2^BHT_BITS x 2-bit saturating predictor table; only
//                 mispredictions redirect.
//     undefined : no table, prediction is always not-taken.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : branch_resolve_unit_if.slave (request, lookup, redirect, flush)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accepting resolve requests
//   FLUSH  | redirect issued; younger instructions being squashed,
//          | incoming requests ignored, counter counts down to 1
module branch_resolve_unit #(
  parameter int WIDTH        = 16,
  parameter int PC_WIDTH     = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_BITS     = 4
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Legal range is 1..15, so four bits always hold the load value.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          cnt_q;
  logic [3:0]          cnt_d;

  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                cond;
  logic                taken;
  logic                eff_pred;
  logic                accept;
  logic                mispredict;
  logic [PC_WIDTH-1:0] next_pc;

  logic                redirect_valid_q;
  logic [PC_WIDTH-1:0] redirect_pc_q;
  logic                flush_q;

  assign op_a = bus.a;
  assign op_b = bus.b;

  // Condition evaluation
  always_comb begin
    cond = 1'b0;
    case (bus.branch_sel)
      3'b000:  cond = ($signed(op_a) < $signed(op_b));
      3'b001:  cond = ($signed(op_a) > $signed(op_b));
      3'b010:  cond = (op_a == op_b);
      3'b011:  cond = (op_a != op_b);
      3'b100:  cond = (op_a < op_b);
      3'b101:  cond = (op_a > op_b);
      default: cond = 1'b0;
    endcase
  end

  // A jump is taken regardless of branch/branch_sel.
  assign taken  = bus.jump | (bus.branch & cond);
  assign accept = bus.valid_in & (state_q == S_IDLE);

  // Jumps always redirect (fetch never predicts them); branches redirect only
  // when the outcome disagrees with what fetch assumed.
  assign mispredict = accept &
                      (bus.jump | (bus.branch & (taken != eff_pred)));

  // Fall-through wraps modulo 2^PC_WIDTH.
  assign next_pc = taken ? bus.target_in : (bus.pc_in + PC_WIDTH'(1));

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs. flush mirrors the next state so it is high exactly
  // while the FSM sits in FLUSH, without decoding state_q combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      redirect_valid_q <= mispredict;
      flush_q          <= (state_d == S_FLUSH);
      if (mispredict) begin
        redirect_pc_q <= next_pc;
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;

`ifdef BRANCH_PREDICT_EN
  localparam int BHT_DEPTH = 1 << BHT_BITS;

  logic [1:0]          bht_q [BHT_DEPTH];
  logic [BHT_BITS-1:0] upd_idx;
  logic [BHT_BITS-1:0] look_idx;
  logic                bht_upd;

  assign upd_idx  = bus.pc_in[BHT_BITS-1:0];
  assign look_idx = bus.pred_pc[BHT_BITS-1:0];

  // Jumps never train the table; requests during FLUSH are not accepted and
  // therefore never train it either.
  assign bht_upd  = accept & bus.branch & ~bus.jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      if (cond) begin
        if (bht_q[upd_idx] != 2'b11) begin
          bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
        end
      end else begin
        if (bht_q[upd_idx] != 2'b00) begin
          bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
        end
      end
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign bus.pred_taken = bht_q[look_idx][1];
  assign eff_pred       = bus.pred_taken_in;
`else
  logic unused_pred;

  assign unused_pred    = ^{bus.pred_taken_in, bus.pred_pc, BHT_BITS[0]};
  assign bus.pred_taken = 1'b0;
  assign eff_pred       = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic clk;
  logic rst;

  int checks;
  int failures;

  branch_resolve_unit_if #(.WIDTH(16), .PC_WIDTH(16)) bus2 ();
  branch_resolve_unit_if #(.WIDTH(16), .PC_WIDTH(16)) bus3 ();

  branch_resolve_unit #(
    .WIDTH(16), .PC_WIDTH(16), .FLUSH_CYCLES(2), .BHT_BITS(4)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  branch_resolve_unit #(
    .WIDTH(16), .PC_WIDTH(16), .FLUSH_CYCLES(3), .BHT_BITS(4)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Second instance sees the same request stream; it is only checked in the
  // reset-during-flush sequence.
  assign bus3.valid_in      = bus2.valid_in;
  assign bus3.branch        = bus2.branch;
  assign bus3.jump          = bus2.jump;
  assign bus3.branch_sel    = bus2.branch_sel;
  assign bus3.a             = bus2.a;
  assign bus3.b             = bus2.b;
  assign bus3.pc_in         = bus2.pc_in;
  assign bus3.target_in     = bus2.target_in;
  assign bus3.pred_taken_in = bus2.pred_taken_in;
  assign bus3.pred_pc       = bus2.pred_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic        branch;
    logic [2:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic        exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic j, input logic br, input logic [2:0] sel,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic [15:0] tgt,
                         input logic pti);
    bus2.valid_in      = 1'b1;
    bus2.jump          = j;
    bus2.branch        = br;
    bus2.branch_sel    = sel;
    bus2.a             = a;
    bus2.b             = b;
    bus2.pc_in         = pc;
    bus2.target_in     = tgt;
    bus2.pred_taken_in = pti;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] last_pc;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus2.valid_in      = 1'b0;
    bus2.jump          = 1'b0;
    bus2.branch        = 1'b0;
    bus2.branch_sel    = 3'b000;
    bus2.a             = '0;
    bus2.b             = '0;
    bus2.pc_in         = '0;
    bus2.target_in     = '0;
    bus2.pred_taken_in = 1'b0;
    bus2.pred_pc       = '0;

    //            jump  br   sel     a         b         pc        tgt       rd
    vec[0]  = '{1'b0, 1'b1, 3'b000, 16'd15,   16'd20,   16'h0010, 16'h0040, 1'b1};
    vec[1]  = '{1'b0, 1'b1, 3'b000, 16'd20,   16'd15,   16'h0011, 16'h0041, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 3'b000, 16'hFFFF, 16'h0001, 16'h0012, 16'h0100, 1'b1};
    vec[3]  = '{1'b0, 1'b1, 3'b100, 16'hFFFF, 16'h0001, 16'h0013, 16'h0101, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 3'b101, 16'hFFFF, 16'h0001, 16'h0014, 16'h0200, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 3'b001, 16'hFFFF, 16'h0001, 16'h0015, 16'h0201, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 3'b010, 16'd7,    16'd7,    16'h0016, 16'h0300, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 3'b010, 16'd7,    16'd8,    16'h0017, 16'h0301, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 3'b011, 16'd7,    16'd8,    16'h0018, 16'h0400, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 3'b011, 16'd7,    16'd7,    16'h0019, 16'h0401, 1'b0};
    vec[10] = '{1'b0, 1'b1, 3'b110, 16'd1,    16'd2,    16'h001A, 16'h0402, 1'b0};
    vec[11] = '{1'b0, 1'b1, 3'b111, 16'd5,    16'd5,    16'h001B, 16'h0403, 1'b0};
    vec[12] = '{1'b1, 1'b0, 3'b110, 16'd10,   16'd10,   16'h001C, 16'h0500, 1'b1};
    vec[13] = '{1'b0, 1'b0, 3'b010, 16'd9,    16'd9,    16'h001D, 16'h0501, 1'b0};
    vec[14] = '{1'b0, 1'b1, 3'b001, 16'h8000, 16'h7FFF, 16'h001E, 16'h0502, 1'b0};
    vec[15] = '{1'b0, 1'b1, 3'b101, 16'h8000, 16'h7FFF, 16'h001F, 16'h0600, 1'b1};
    vec[16] = '{1'b0, 1'b1, 3'b100, 16'h7FFF, 16'h8000, 16'h0020, 16'h0700, 1'b1};
    vec[17] = '{1'b1, 1'b1, 3'b011, 16'd3,    16'd3,    16'h0021, 16'h0800, 1'b1};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_redirect_valid", {15'd0, bus2.redirect_valid}, 16'd0);
    chk("rst_redirect_pc", bus2.redirect_pc, 16'h0000);
    chk("rst_flush", {15'd0, bus2.flush}, 16'd0);
    chk("rst_pred_taken", {15'd0, bus2.pred_taken}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven single requests, FLUSH_CYCLES = 2
    last_pc = 16'h0000;
    for (int i = 0; i < NV; i++) begin
      set_req(vec[i].jump, vec[i].branch, vec[i].sel, vec[i].a, vec[i].b,
              vec[i].pc, vec[i].tgt, 1'b0);
      @(negedge clk);
      bus2.valid_in = 1'b0;
      if (vec[i].exp_rd) last_pc = vec[i].tgt;
      chk($sformatf("v%0d_redirect_valid", i), {15'd0, bus2.redirect_valid}, {15'd0, vec[i].exp_rd});
      chk($sformatf("v%0d_flush_c1", i), {15'd0, bus2.flush}, {15'd0, vec[i].exp_rd});
      chk($sformatf("v%0d_redirect_pc", i), bus2.redirect_pc, last_pc);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), {15'd0, bus2.redirect_valid}, 16'd0);
      chk($sformatf("v%0d_flush_c2", i), {15'd0, bus2.flush}, {15'd0, vec[i].exp_rd});
      @(negedge clk);
      chk($sformatf("v%0d_flush_c3", i), {15'd0, bus2.flush}, 16'd0);
    end

    // requests during flush are ignored; back-to-back after flush is accepted
    do_reset();
    set_req(1'b1, 1'b0, 3'b110, 16'd10, 16'd10, 16'h0030, 16'h0A00, 1'b0);
    @(negedge clk);
    chk("ff_redirect", {15'd0, bus2.redirect_valid}, 16'd1);
    chk("ff_pc", bus2.redirect_pc, 16'h0A00);
    set_req(1'b1, 1'b0, 3'b110, 16'd0, 16'd0, 16'h0031, 16'h0B00, 1'b0);
    @(negedge clk);
    chk("ff_ignored_c2", {15'd0, bus2.redirect_valid}, 16'd0);
    chk("ff_flush_c2", {15'd0, bus2.flush}, 16'd1);
    set_req(1'b1, 1'b0, 3'b110, 16'd0, 16'd0, 16'h0032, 16'h0C00, 1'b0);
    @(negedge clk);
    chk("ff_ignored_c3", {15'd0, bus2.redirect_valid}, 16'd0);
    chk("ff_flush_drop", {15'd0, bus2.flush}, 16'd0);
    chk("ff_pc_hold", bus2.redirect_pc, 16'h0A00);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("b2b_redirect", {15'd0, bus2.redirect_valid}, 16'd1);
    chk("b2b_pc", bus2.redirect_pc, 16'h0C00);
    chk("b2b_flush", {15'd0, bus2.flush}, 16'd1);
    @(negedge clk);
    @(negedge clk);

    // async reset in second flush cycle, FLUSH_CYCLES = 3
    do_reset();
    set_req(1'b1, 1'b0, 3'b110, 16'd0, 16'd0, 16'h0040, 16'h0ABC, 1'b0);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("r3_redirect", {15'd0, bus3.redirect_valid}, 16'd1);
    chk("r3_flush_c1", {15'd0, bus3.flush}, 16'd1);
    @(posedge clk);
    #2;
    chk("r3_flush_c2", {15'd0, bus3.flush}, 16'd1);
    rst = 1'b1;
    #1;
    chk("r3_async_flush", {15'd0, bus3.flush}, 16'd0);
    chk("r3_async_rv", {15'd0, bus3.redirect_valid}, 16'd0);
    chk("r3_async_pc", bus3.redirect_pc, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r3_post_flush", {15'd0, bus3.flush}, 16'd0);
    set_req(1'b1, 1'b0, 3'b110, 16'd0, 16'd0, 16'h0041, 16'h0123, 1'b0);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("r3_idle_accept", {15'd0, bus3.redirect_valid}, 16'd1);
    chk("r3_idle_pc", bus3.redirect_pc, 16'h0123);
    chk("r3_idle_flush", {15'd0, bus3.flush}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

`ifdef BRANCH_PREDICT_EN
    do_reset();
    bus2.pred_pc = 16'h0003;
    #1;
    chk("bp_init", {15'd0, bus2.pred_taken}, 16'd0);
    set_req(1'b0, 1'b1, 3'b010, 16'd1, 16'd1, 16'h0003, 16'h0040, 1'b0);
    #1;
    chk("bp_pre_update", {15'd0, bus2.pred_taken}, 16'd0);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("bp_first_redirect", {15'd0, bus2.redirect_valid}, 16'd1);
    chk("bp_first_pc", bus2.redirect_pc, 16'h0040);
    chk("bp_cnt10", {15'd0, bus2.pred_taken}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'b010, 16'd1, 16'd1, 16'h0003, 16'h0040, 1'b1);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("bp_second_rv", {15'd0, bus2.redirect_valid}, 16'd0);
    chk("bp_second_flush", {15'd0, bus2.flush}, 16'd0);
    chk("bp_cnt11", {15'd0, bus2.pred_taken}, 16'd1);
    set_req(1'b0, 1'b1, 3'b010, 16'd1, 16'd2, 16'hFFFF, 16'h1234, 1'b1);
    @(negedge clk);
    chk("bp_wrap_rv", {15'd0, bus2.redirect_valid}, 16'd1);
    chk("bp_wrap_pc", bus2.redirect_pc, 16'h0000);
    set_req(1'b0, 1'b1, 3'b010, 16'd1, 16'd2, 16'h0003, 16'h1234, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    chk("bp_flush_done", {15'd0, bus2.flush}, 16'd0);
    chk("bp_no_update", {15'd0, bus2.pred_taken}, 16'd1);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
